// File: rtl/bus_trace_recorder.sv
// Passive CPU-bus snooper: completed accesses and IRQ rising edges become
// timestamped records, queued in a first-word-fall-through FIFO with drop accounting.
module bus_trace_recorder #(
    parameter  int ADDR_W = 4,
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    parameter  int CNT_W  = 8,
    localparam int REC_W  = 2 + ADDR_W + DATA_W + 48,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cap_wr_en,
    input  logic              cap_rd_en,
    input  logic              cap_irq_en,
    input  logic              clr,
    input  logic [ADDR_W-1:0] AddrBus,
    input  logic              n_ChipSelect,
    input  logic              n_rd,
    input  logic              n_we,
    input  logic [DATA_W-1:0] DataBusI,
    input  logic [DATA_W-1:0] DataBusO,
    input  logic              p_IrqSig,
    input  logic [3:0]        acqurate_stamp,
    input  logic [11:0]       millisecond_stamp,
    input  logic [31:0]       second_stamp,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [REC_W-1:0]  rec_data,
    output logic [AW:0]       level,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              overflow
);
    typedef struct packed {
        logic [1:0]        kind;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [47:0]       stamp;   // {sec, ms, acq}
    } rec_t;

    localparam logic [1:0] K_WR  = 2'b00;
    localparam logic [1:0] K_RD  = 2'b01;
    localparam logic [1:0] K_IRQ = 2'b10;
    localparam logic [1:0] K_ERR = 2'b11;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic        wr_act, rd_act, err_act, act;
    logic [1:0]  cur_kind;
    logic [47:0] stamp;

    assign wr_act  = !n_ChipSelect && !n_we &&  n_rd;
    assign rd_act  = !n_ChipSelect && !n_rd &&  n_we;
    assign err_act = !n_ChipSelect && !n_rd && !n_we;
    assign act     = wr_act || rd_act || err_act;
    assign stamp   = {second_stamp, millisecond_stamp, acqurate_stamp};

    always_comb begin
        cur_kind = K_WR;
        if (rd_act)       cur_kind = K_RD;
        else if (err_act) cur_kind = K_ERR;
    end

    // ---------------- access tracking ----------------
    logic       prev_act, armed, tracking;
    logic [1:0] prev_kind;
    rec_t       acc_rec;
    logic       acc_start, acc_end, kind_en, acc_push;

    assign acc_start = act && (!prev_act || cur_kind != prev_kind);
    assign acc_end   = prev_act && (!act || cur_kind != prev_kind);

    // Error accesses have no dedicated enable; only the global enable gates them.
    always_comb begin
        kind_en = 1'b1;
        case (acc_rec.kind)
            K_WR:    kind_en = cap_wr_en;
            K_RD:    kind_en = cap_rd_en;
            default: kind_en = 1'b1;
        endcase
    end

    assign acc_push = acc_end && tracking && enable && kind_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_act  <= 1'b0;
            prev_kind <= K_WR;
            armed     <= 1'b0;
            tracking  <= 1'b0;
            acc_rec   <= '0;
        end else begin
            prev_act  <= act;
            prev_kind <= cur_kind;
            if (!act) armed <= 1'b1;
            // an access already in progress when reset released is never tracked
            if (acc_start)   tracking <= armed && enable;
            else if (!act)   tracking <= 1'b0;
            if (act) begin
                acc_rec.addr <= AddrBus;
                acc_rec.data <= (cur_kind == K_RD) ? DataBusO : DataBusI;
            end
            if (acc_start) begin
                acc_rec.kind  <= cur_kind;
                acc_rec.stamp <= stamp;
            end
        end
    end

    // ---------------- IRQ capture ----------------
    logic        irq_prev, irq_pend, irq_edge, irq_take, irq_drop;
    logic [47:0] irq_stamp;
    rec_t        irq_rec;

    assign irq_edge = p_IrqSig && !irq_prev && cap_irq_en && enable;
    assign irq_drop = irq_edge && irq_pend && acc_push;
    assign irq_take = irq_edge && !irq_drop;

    always_comb begin
        irq_rec       = '0;
        irq_rec.kind  = K_IRQ;
        irq_rec.stamp = irq_stamp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev  <= 1'b0;
            irq_pend  <= 1'b0;
            irq_stamp <= '0;
        end else begin
            irq_prev <= p_IrqSig;
            if (clr) begin
                irq_pend <= 1'b0;
            end else if (irq_take) begin
                irq_pend  <= 1'b1;
                irq_stamp <= stamp;
            end else if (irq_pend && !acc_push) begin
                irq_pend <= 1'b0;
            end
        end
    end

    // ---------------- FIFO ----------------
    rec_t             mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push_req, push_ok, push_drop, pop, full;
    rec_t             push_rec;
    logic [CNT_W+1:0] drop_sum;

    assign full      = (count == FULL_LVL);
    assign pop       = rec_valid && rec_ready;
    assign push_req  = acc_push || irq_pend;
    assign push_rec  = acc_push ? acc_rec : irq_rec;
    assign push_ok   = push_req && (!full || pop);
    assign push_drop = push_req && full && !pop;
    assign drop_sum  = {2'b00, drop_cnt} + (CNT_W+2)'(push_drop) + (CNT_W+2)'(irq_drop);

    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem[wr_ptr] <= push_rec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
            if (drop_sum[CNT_W+1:CNT_W] != 2'b00) drop_cnt <= '1;
            else                                  drop_cnt <= drop_sum[CNT_W-1:0];
            if (push_drop || irq_drop) overflow <= 1'b1;
        end
    end

    assign rec_valid = (count != '0);
    assign rec_data  = rec_valid ? mem[rd_ptr] : '0;
    assign level     = count;

endmodule

// File: tb/tb_bus_trace_recorder.sv
// Directed + randomized bench for bus_trace_recorder; expected records come
// from a transaction-level queue model of the recorder.
module tb_bus_trace_recorder;
    localparam int DEPTH = 16;
    localparam logic [1:0] K_WR = 2'b00, K_RD = 2'b01, K_IRQ = 2'b10, K_ERR = 2'b11;

    typedef struct packed {
        logic [1:0]  kind;
        logic [3:0]  addr;
        logic [7:0]  data;
        logic [47:0] stamp;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst, enable, cap_wr_en, cap_rd_en, cap_irq_en, clr;
    logic [3:0]  AddrBus;
    logic        n_ChipSelect, n_rd, n_we;
    logic [7:0]  DataBusI, DataBusO;
    logic        p_IrqSig;
    logic [3:0]  acqurate_stamp;
    logic [11:0] millisecond_stamp;
    logic [31:0] second_stamp;
    logic        rec_valid, rec_ready;
    logic [61:0] rec_data;
    logic [4:0]  level;
    logic [7:0]  drop_cnt;
    logic        overflow;

    bus_trace_recorder dut (
        .clk(clk), .rst(rst), .enable(enable), .cap_wr_en(cap_wr_en), .cap_rd_en(cap_rd_en),
        .cap_irq_en(cap_irq_en), .clr(clr), .AddrBus(AddrBus), .n_ChipSelect(n_ChipSelect),
        .n_rd(n_rd), .n_we(n_we), .DataBusI(DataBusI), .DataBusO(DataBusO), .p_IrqSig(p_IrqSig),
        .acqurate_stamp(acqurate_stamp), .millisecond_stamp(millisecond_stamp),
        .second_stamp(second_stamp), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_data(rec_data), .level(level), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   errors  = 0;
    rec_t exp_q[$];
    int   exp_drops = 0;
    rec_t cur_exp;
    bit   cur_valid = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit ken(input logic [1:0] k);
        if (k == K_WR) return cap_wr_en;
        if (k == K_RD) return cap_rd_en;
        return 1'b1;
    endfunction

    // FIFO model: capacity DEPTH, overflow drops counted (saturating)
    function automatic void model_push(input rec_t r);
        if (exp_q.size() < DEPTH) exp_q.push_back(r);
        else if (exp_drops < 255) exp_drops++;
    endfunction

    task automatic rand_stamp();
        second_stamp      = $urandom;
        millisecond_stamp = 12'($urandom);
        acqurate_stamp    = 4'($urandom);
    endtask

    // Drive an n-cycle access; bus is left active. A different kind started
    // without an idle cycle closes the previous access.
    task automatic bus_access(input logic [1:0] k, input logic [3:0] a, input int n,
                              input logic [7:0] d0, input logic [7:0] dl);
        logic [7:0] d;
        if (cur_valid && enable && ken(cur_exp.kind)) model_push(cur_exp);
        cur_valid     = enable && ken(k);
        cur_exp.kind  = k;
        cur_exp.addr  = a;
        cur_exp.data  = dl;
        cur_exp.stamp = {second_stamp, millisecond_stamp, acqurate_stamp};
        for (int i = 0; i < n; i++) begin
            d = (i == n - 1) ? dl : (i == 0) ? d0 : 8'($urandom);
            if (i > 0) rand_stamp();
            n_ChipSelect = 1'b0;
            n_we     = !(k == K_WR || k == K_ERR);
            n_rd     = !(k == K_RD || k == K_ERR);
            AddrBus  = a;
            DataBusI = (k != K_RD) ? d : 8'($urandom);
            DataBusO = (k == K_RD) ? d : 8'($urandom);
            tick();
        end
    endtask

    task automatic bus_idle();
        n_ChipSelect = 1'b1;
        n_rd = 1'b1;
        n_we = 1'b1;
        if (cur_valid && enable && ken(cur_exp.kind)) model_push(cur_exp);
        cur_valid = 0;
    endtask

    task automatic irq_fire();
        second_stamp      = second_stamp + 1;
        millisecond_stamp = 12'($urandom);
        p_IrqSig = 1'b1;
        if (enable && cap_irq_en)
            model_push('{kind: K_IRQ, addr: 4'h0, data: 8'h00,
                         stamp: {second_stamp, millisecond_stamp, acqurate_stamp}});
    endtask

    task automatic drain(input bit rnd);
        int guard = 0;
        tick();
        while (exp_q.size() != 0 && guard < 2000) begin
            rec_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            chk("rec_valid_drain", 64'(rec_valid), 64'd1);
            if (rec_valid !== 1'b1) break;
            chk("rec_data_drain", 64'(rec_data), 64'(exp_q[0]));
            if (rec_ready) void'(exp_q.pop_front());
            tick();
            guard++;
        end
        if (guard >= 2000) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        rec_ready = 1'b0;
        @(negedge clk);
        chk("level_drained", 64'(level), 64'd0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; enable = 1'b1; cap_wr_en = 1'b1; cap_rd_en = 1'b1; cap_irq_en = 1'b1;
        clr = 1'b0; AddrBus = '0; n_ChipSelect = 1'b1; n_rd = 1'b1; n_we = 1'b1;
        DataBusI = '0; DataBusO = '0; p_IrqSig = 1'b0; rec_ready = 1'b0;
        acqurate_stamp = '0; millisecond_stamp = '0; second_stamp = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(rec_valid), 64'd0);
        chk("rst_data", 64'(rec_data), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;
        tick(); tick();

        // directed write, latency check
        second_stamp = 32'd1; millisecond_stamp = 12'd7; acqurate_stamp = 4'd0;
        bus_access(K_WR, 4'h3, 3, 8'hA5, 8'hA5);
        bus_idle();
        @(negedge clk);
        chk("wr_valid_early", 64'(rec_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("wr_valid", 64'(rec_valid), 64'd1);
        chk("wr_record", 64'(rec_data), 64'({2'b00, 4'h3, 8'hA5, 32'd1, 12'd7, 4'd0}));
        chk("wr_level", 64'(level), 64'd1);
        drain(0);

        // read: last active cycle's DataBusO wins
        rand_stamp();
        bus_access(K_RD, 4'hC, 2, 8'h11, 8'h5A);
        bus_idle();
        tick(); tick();
        @(negedge clk);
        chk("rd_addr_data", 64'(rec_data[59:48]), 64'h0C5A);
        drain(0);

        // IRQ edge coincident with write end
        rand_stamp();
        bus_access(K_WR, 4'h5, 2, 8'($urandom), 8'($urandom));
        bus_idle();
        irq_fire();
        tick();
        p_IrqSig = 1'b0;
        tick();
        @(negedge clk);
        chk("irq_level", 64'(level), 64'd2);
        drain(0);

        // kind change without idle: write then read
        rand_stamp();
        bus_access(K_WR, 4'h1, 2, 8'($urandom), 8'($urandom));
        rand_stamp();
        bus_access(K_RD, 4'h2, 2, 8'($urandom), 8'($urandom));
        bus_idle();
        tick(); tick();
        drain(0);

        // randomized rounds with random enables and IRQs
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 7; i++) begin
                logic [1:0] k;
                enable     = ($urandom_range(0, 3) != 0);
                cap_wr_en  = ($urandom_range(0, 3) != 0);
                cap_rd_en  = ($urandom_range(0, 3) != 0);
                cap_irq_en = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 2))
                    0:       k = K_WR;
                    1:       k = K_RD;
                    default: k = K_ERR;
                endcase
                rand_stamp();
                bus_access(k, 4'($urandom), $urandom_range(1, 4), 8'($urandom), 8'($urandom));
                bus_idle();
                if ($urandom_range(0, 1) == 1) irq_fire();
                tick();
                p_IrqSig = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
            end
            enable = 1'b1; cap_wr_en = 1'b1; cap_rd_en = 1'b1; cap_irq_en = 1'b1;
            tick();
            drain(1);
        end

        // overflow: 20 writes into a 16-deep FIFO with no consumer
        for (int i = 0; i < 20; i++) begin
            rand_stamp();
            bus_access(K_WR, 4'(i), 1, 8'($urandom), 8'($urandom));
            bus_idle();
            tick();
        end
        @(negedge clk);
        chk("full_level", 64'(level), 64'd16);
        chk("full_drop", 64'(drop_cnt), 64'(exp_drops));
        chk("full_drop4", 64'(drop_cnt), 64'd4);
        chk("full_ovf", 64'(overflow), 64'd1);
        tick();

        // full FIFO: pop and access end in the same cycle
        rand_stamp();
        bus_access(K_WR, 4'hE, 1, 8'h3C, 8'h3C);
        rec_ready = 1'b1;
        chk("full_head", 64'(rec_data), 64'(exp_q[0]));
        void'(exp_q.pop_front());
        bus_idle();
        tick();
        rec_ready = 1'b0;
        @(negedge clk);
        chk("fullpop_level", 64'(level), 64'd16);
        chk("fullpop_drop", 64'(drop_cnt), 64'd4);
        drain(0);

        // clr flushes FIFO and clears drop accounting
        for (int i = 0; i < 3; i++) begin
            rand_stamp();
            bus_access(K_WR, 4'(i), 1, 8'($urandom), 8'($urandom));
            bus_idle();
            tick();
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_q.delete();
        exp_drops = 0;
        @(negedge clk);
        chk("clr_level", 64'(level), 64'd0);
        chk("clr_valid", 64'(rec_valid), 64'd0);
        chk("clr_drop", 64'(drop_cnt), 64'd0);
        chk("clr_ovf", 64'(overflow), 64'd0);
        tick();

        // clr during an access does not cancel it
        rand_stamp();
        bus_access(K_WR, 4'h9, 2, 8'($urandom), 8'($urandom));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        bus_idle();
        tick(); tick();
        drain(0);

        // async reset mid-access, released while bus still active
        rand_stamp();
        bus_access(K_WR, 4'h7, 1, 8'h01, 8'h01);
        bus_idle();
        tick(); tick();
        rand_stamp();
        bus_access(K_WR, 4'h6, 2, 8'($urandom), 8'($urandom));
        rst = 1'b1;
        #2;
        chk("arst_level", 64'(level), 64'd0);
        chk("arst_valid", 64'(rec_valid), 64'd0);
        exp_q.delete();
        exp_drops = 0;
        cur_valid = 0;
        tick();
        rst = 1'b0;
        tick(); tick();
        bus_idle();
        tick(); tick();
        @(negedge clk);
        chk("arst_norec", 64'(level), 64'd0);
        tick();
        rand_stamp();
        bus_access(K_RD, 4'hB, 2, 8'($urandom), 8'($urandom));
        bus_idle();
        tick(); tick();
        drain(0);
        @(negedge clk);
        chk("final_drop", 64'(drop_cnt), 64'(exp_drops));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
